null_instr_decode_unit: RTL and testbench

NULL_INSTR_DECODE_UNIT -- requirements
Module: null_instr_decode_unit

---
 rtl/null_instr_decode_unit.sv | 127 ++++++++++++
 tb/tb_null_instr_decode_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/null_instr_decode_unit.sv
// null_instr_decode_unit
//
// Decodes a 12-bit instruction (and the board switch value) into a packed
// 55-bit ALU control word. The decode is combinational; the word and every
// field output are registered, giving one cycle of latency.
//
// Optional feature macro: NULL_DECODER_LDSW_EN
//   defined   - opcode 0001 (ldsw) loads the switch value through ALU input A
//   undefined - opcode 0001 decodes as a noop and switches is unused
//
// Ports
//   clk                        in   sole clock, rising edge
//   rst_n                      in   asynchronous active-low reset
//   instruction[11:0]          in   [11:8] opcode, [7:4] field X, [3:0] field Y
//   switches[15:0]             in   board switch value
//   control_word[54:0]         out  registered packed control word
//   program_counter_increment  out  control_word[54]
//   alu_op[3:0]                out  control_word[53:50]
//   alu_a_altern[15:0]         out  control_word[49:34]
//   alu_b_altern[15:0]         out  control_word[33:18]
//   alu_a_select[3:0]          out  control_word[17:14]
//   alu_b_select[3:0]          out  control_word[13:10]
//   alu_a_source               out  control_word[9]   (1 = altern, 0 = register)
//   alu_b_source               out  control_word[8]   (1 = altern, 0 = register)
//   alu_out_select[3:0]        out  control_word[7:4]
//   alu_load_src[1:0]          out  control_word[3:2]
//   alu_store_to_mem           out  control_word[1]
//   alu_store_to_stk           out  control_word[0]

module null_instr_decode_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] instruction,
    input  logic [15:0] switches,
    output logic [54:0] control_word,
    output logic        program_counter_increment,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a_altern,
    output logic [15:0] alu_b_altern,
    output logic [3:0]  alu_a_select,
    output logic [3:0]  alu_b_select,
    output logic        alu_a_source,
    output logic        alu_b_source,
    output logic [3:0]  alu_out_select,
    output logic [1:0]  alu_load_src,
    output logic        alu_store_to_mem,
    output logic        alu_store_to_stk
);

    logic [3:0]  opcode;
    logic [3:0]  field_x;
    logic [3:0]  field_y;
    logic [54:0] word_d;
    logic [54:0] word_q;

    assign opcode  = instruction[11:8];
    assign field_x = instruction[7:4];
    assign field_y = instruction[3:0];

`ifndef NULL_DECODER_LDSW_EN
    // Switches only feed the ldsw path; keep them referenced without effect.
    logic unused_switches;
    assign unused_switches = ^switches;
`endif

    always_comb begin
        // Noop word: only the PC increment is set; every other field is zero.
        word_d     = '0;
        word_d[54] = 1'b1;

        if (opcode[3]) begin
            // Memory / stack group: opcode[0] selects the offset (IADD) form.
            word_d[53:50] = {3'b000, opcode[0]};
            word_d[17:14] = field_x;
            word_d[13:10] = field_y;
            word_d[7:4]   = field_y;
            // opcode[2] = write, opcode[1] = stack (vs memory).
            unique case (opcode[2:1])
                2'b00: word_d[3:2] = 2'b10;
                2'b01: word_d[3:2] = 2'b11;
                2'b10: begin
                    word_d[3:2] = 2'b01;
                    word_d[1]   = 1'b1;
                end
                2'b11: begin
                    word_d[3:2] = 2'b01;
                    word_d[0]   = 1'b1;
                end
                default: word_d[3:2] = 2'b00;
            endcase
        end
`ifdef NULL_DECODER_LDSW_EN
        else if (opcode == 4'b0001) begin
            // ldsw: switches enter through ALU input A's alternate path.
            word_d[53:50] = field_x;
            word_d[49:34] = switches;
            word_d[9]     = 1'b1;
            word_d[13:10] = field_y;
            word_d[7:4]   = field_y;
            word_d[3:2]   = 2'b01;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign control_word              = word_q;
    assign program_counter_increment = word_q[54];
    assign alu_op                    = word_q[53:50];
    assign alu_a_altern              = word_q[49:34];
    assign alu_b_altern              = word_q[33:18];
    assign alu_a_select              = word_q[17:14];
    assign alu_b_select              = word_q[13:10];
    assign alu_a_source              = word_q[9];
    assign alu_b_source              = word_q[8];
    assign alu_out_select            = word_q[7:4];
    assign alu_load_src              = word_q[3:2];
    assign alu_store_to_mem          = word_q[1];
    assign alu_store_to_stk          = word_q[0];

endmodule

// File: tb/tb_null_instr_decode_unit.sv
// Scoreboard bench for null_instr_decode_unit. Stimulus pushes the model's
// expected control fields into a queue; a monitor pops one entry per clock
// edge and compares the word and every field output.
module tb_null_instr_decode_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] instruction;
    logic [15:0] switches;
    logic [54:0] control_word;
    logic        program_counter_increment;
    logic [3:0]  alu_op;
    logic [15:0] alu_a_altern;
    logic [15:0] alu_b_altern;
    logic [3:0]  alu_a_select;
    logic [3:0]  alu_b_select;
    logic        alu_a_source;
    logic        alu_b_source;
    logic [3:0]  alu_out_select;
    logic [1:0]  alu_load_src;
    logic        alu_store_to_mem;
    logic        alu_store_to_stk;

    // Field layout in control-word order, MSB first.
    typedef struct packed {
        logic        pc_inc;
        logic [3:0]  op;
        logic [15:0] a_alt;
        logic [15:0] b_alt;
        logic [3:0]  a_sel;
        logic [3:0]  b_sel;
        logic        a_src;
        logic        b_src;
        logic [3:0]  out_sel;
        logic [1:0]  load;
        logic        st_mem;
        logic        st_stk;
    } ctl_t;

    ctl_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    null_instr_decode_unit dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .instruction               (instruction),
        .switches                  (switches),
        .control_word              (control_word),
        .program_counter_increment (program_counter_increment),
        .alu_op                    (alu_op),
        .alu_a_altern              (alu_a_altern),
        .alu_b_altern              (alu_b_altern),
        .alu_a_select              (alu_a_select),
        .alu_b_select              (alu_b_select),
        .alu_a_source              (alu_a_source),
        .alu_b_source              (alu_b_source),
        .alu_out_select            (alu_out_select),
        .alu_load_src              (alu_load_src),
        .alu_store_to_mem          (alu_store_to_mem),
        .alu_store_to_stk          (alu_store_to_stk)
    );

    always #5 clk = ~clk;

    // Reference decode written from the opcode table.
    function automatic ctl_t model(input logic [11:0] ins, input logic [15:0] sw);
        ctl_t c;
        int   opc;
        c        = '0;
        c.pc_inc = 1'b1;
        opc      = int'(ins[11:8]);
        if (opc >= 8) begin
            c.op      = (opc % 2 == 1) ? 4'd1 : 4'd0;
            c.a_sel   = ins[7:4];
            c.b_sel   = ins[3:0];
            c.out_sel = ins[3:0];
            case (opc)
                8, 9:   c.load = 2'd2;
                10, 11: c.load = 2'd3;
                12, 13: begin c.load = 2'd1; c.st_mem = 1'b1; end
                default: begin c.load = 2'd1; c.st_stk = 1'b1; end
            endcase
        end
`ifdef NULL_DECODER_LDSW_EN
        else if (opc == 1) begin
            c.op      = ins[7:4];
            c.a_alt   = sw;
            c.a_src   = 1'b1;
            c.b_sel   = ins[3:0];
            c.out_sel = ins[3:0];
            c.load    = 2'd1;
        end
`else
        if (sw == 16'hFFFF) c.b_alt = '0; // switches have no effect here
`endif
        return c;
    endfunction

    task automatic check(input string name, input logic [54:0] act, input logic [54:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic drive(input logic [11:0] ins, input logic [15:0] sw);
        @(negedge clk);
        instruction = ins;
        switches    = sw;
        exp_q.push_back(model(ins, sw));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_word"}, control_word, '0);
        check({name, "_pcinc"}, 55'(program_counter_increment), '0);
        check({name, "_fields"},
              {program_counter_increment, alu_op, alu_a_altern, alu_b_altern, alu_a_select,
               alu_b_select, alu_a_source, alu_b_source, alu_out_select, alu_load_src,
               alu_store_to_mem, alu_store_to_stk}, '0);
    endtask

    // Monitor: every edge after a push presents one decoded word.
    always @(posedge clk) begin
        ctl_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("word", control_word, e);
            check("pc_inc", 55'(program_counter_increment), 55'(e.pc_inc));
            check("alu_op", 55'(alu_op), 55'(e.op));
            check("a_altern", 55'(alu_a_altern), 55'(e.a_alt));
            check("b_altern", 55'(alu_b_altern), 55'(e.b_alt));
            check("a_select", 55'(alu_a_select), 55'(e.a_sel));
            check("b_select", 55'(alu_b_select), 55'(e.b_sel));
            check("a_source", 55'(alu_a_source), 55'(e.a_src));
            check("b_source", 55'(alu_b_source), 55'(e.b_src));
            check("out_select", 55'(alu_out_select), 55'(e.out_sel));
            check("load_src", 55'(alu_load_src), 55'(e.load));
            check("store_mem", 55'(alu_store_to_mem), 55'(e.st_mem));
            check("store_stk", 55'(alu_store_to_stk), 55'(e.st_stk));
            check("stores_exclusive", 55'(alu_store_to_mem & alu_store_to_stk), '0);
        end
    end

    initial begin
        logic [11:0] dir [14];
        dir = '{12'h000, 12'h200, 12'h300, 12'h4FF, 12'h105, 12'h1B7, 12'h801,
                12'h901, 12'hC01, 12'hD01, 12'hA01, 12'hB01, 12'hE01, 12'hF01};

        // Reset held with an ldsw instruction present.
        rst_n       = 1'b0;
        instruction = 12'h1A5;
        switches    = 16'h1242;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_hold");
        rst_n = 1'b1;
        exp_q.push_back(model(instruction, switches));

        foreach (dir[i]) drive(dir[i], 16'h1242);
        drive(12'h4FF, 16'h1242);
        @(posedge clk);
        #2;
        check("noop_const", control_word, 55'h40000000000000);

        drive(12'h105, 16'h1242);
        @(posedge clk);
        #2;
`ifdef NULL_DECODER_LDSW_EN
        check("ldsw_const", control_word, {1'b1, 4'h0, 16'h1242, 16'h0, 4'h0, 4'h5,
                                           1'b1, 1'b0, 4'h5, 2'b01, 2'b00});
`else
        check("ldsw_noop_const", control_word, 55'h40000000000000);
`endif

        for (int i = 0; i < 200; i++) drive(12'($urandom), 16'($urandom));

        // Reset mid-stream, asserted away from any clock edge.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_async");
        @(negedge clk);
        instruction = 12'hE37;
        switches    = 16'hBEEF;
        rst_n       = 1'b1;
        exp_q.push_back(model(instruction, switches));

        for (int i = 0; i < 100; i++) drive(12'($urandom), 16'($urandom));

        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", 55'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
